// File: rtl/mmio_queue_pkg.sv
// mmio_queue register map, status/ctrl bit layout
// and the read/write address decode helper.
package mmio_queue_pkg;

  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_PEEK   = 16'd2;
  localparam logic [15:0] OFS_STATUS = 16'd4;
  localparam logic [15:0] OFS_CTRL   = 16'd6;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_UDF   = 11;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  typedef logic [8:0] t_mmio_tid;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_PEEK,
    SEL_STATUS,
    SEL_CTRL
  } t_sel;

  function automatic t_sel decode(
    input logic [15:0] addr,
    input logic [15:0] base
  );
    logic [15:0] ofs;
    ofs = addr - base;
    if (ofs == OFS_DATA)        return SEL_DATA;
    else if (ofs == OFS_PEEK)   return SEL_PEEK;
    else if (ofs == OFS_STATUS) return SEL_STATUS;
    else if (ofs == OFS_CTRL)   return SEL_CTRL;
    else                        return SEL_NONE;
  endfunction

endpackage

// File: rtl/mmio_queue_store.sv
// Circular storage for mmio_queue: array, head/tail,
// occupancy. Pop reads head combinationally.
module mmio_queue_store
  import mmio_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] wdata,
  output logic [63:0] head,
  output logic [7:0]  count,
  output logic        full,
  output logic        empty
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [7:0]    r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (r_count == 8'(DEPTH));
  assign empty = (r_count == 8'd0);
  assign count = r_count;
  assign head  = r_mem[r_head];

  // A full queue still accepts a push when a pop frees the slot.
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;

  // Pointer and occupancy update; flush overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= bump(r_tail);
      if (w_do_pop)  r_head <= bump(r_head);
      if (w_do_push && !w_do_pop)
        r_count <= r_count + 8'd1;
      else if (!w_do_push && w_do_pop)
        r_count <= r_count - 8'd1;
    end
  end

  // Entry write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_tail] <= wdata;
  end

endmodule

// File: rtl/mmio_queue.sv
// MMIO-mapped 64-bit FIFO: address decode, sticky
// flags and the registered 1-cycle read response.
module mmio_queue
  import mmio_queue_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic        rd_valid,
  input  logic [15:0] rd_addr,
  input  logic [8:0]  rd_tid,
  output logic        resp_valid,
  output logic [8:0]  resp_tid,
  output logic [63:0] resp_data,
  output logic [7:0]  count
);

  t_sel        w_wsel;
  t_sel        w_rsel;
  logic        w_push;
  logic        w_pop;
  logic        w_ctrl;
  logic        w_flush;
  logic        w_clr;
  logic        w_hit;
  logic [63:0] w_head;
  logic [7:0]  w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf_set;
  logic        w_udf_set;
  logic [63:0] w_status;
  logic [63:0] w_rdata;

  logic        r_ovf;
  logic        r_udf;
  logic        r_resp_valid;
  t_mmio_tid   r_resp_tid;
  logic [63:0] r_resp_data;

  assign w_wsel  = decode(wr_addr, BASE_ADDR);
  assign w_rsel  = decode(rd_addr, BASE_ADDR);
  assign w_push  = wr_valid & (w_wsel == SEL_DATA);
  assign w_ctrl  = wr_valid & (w_wsel == SEL_CTRL);
  assign w_flush = w_ctrl & wr_data[CTRL_FLUSH];
  assign w_clr   = w_ctrl & wr_data[CTRL_CLR];
  assign w_pop   = rd_valid & (w_rsel == SEL_DATA);
  assign w_hit   = rd_valid & (w_rsel != SEL_NONE);

  // Full implies non-empty, so a same-cycle pop always frees room.
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_udf_set = w_pop & w_empty;

  mmio_queue_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (wr_data),
    .head  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Status word built from pre-update state.
  always_comb begin
    w_status           = '0;
    w_status[7:0]      = w_count;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_UDF]   = r_udf;
  end

  // Read data select; empty pops/peeks return zero.
  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (w_rsel == SEL_DATA),
      (w_rsel == SEL_PEEK):   w_rdata = w_empty ? '0 : w_head;
      (w_rsel == SEL_STATUS): w_rdata = w_status;
      default:                w_rdata = '0;
    endcase
  end

  // Sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~w_clr);
      r_udf <= w_udf_set | (r_udf & ~w_clr);
    end
  end

  // Response register; data holds on misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_tid   <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_hit;
      if (w_hit) begin
        r_resp_tid  <= rd_tid;
        r_resp_data <= w_rdata;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_tid   = r_resp_tid;
  assign resp_data  = r_resp_data;
  assign count      = w_count;

endmodule

// File: tb/tb_mmio_queue.sv
// Scoreboard bench for mmio_queue: reads queue an
// expected response, a negedge monitor checks it.
module tb_mmio_queue;

  localparam logic [15:0] A_DATA = 16'h0020;
  localparam logic [15:0] A_PEEK = 16'h0022;
  localparam logic [15:0] A_STAT = 16'h0024;
  localparam logic [15:0] A_CTRL = 16'h0026;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [8:0]  rd_tid;
  logic        resp_valid;
  logic [8:0]  resp_tid;
  logic [63:0] resp_data;
  logic [7:0]  count;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   tidn   = 17;

  mmio_queue #(
    .DEPTH     (8),
    .BASE_ADDR (16'h0020)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_tid     (rd_tid),
    .resp_valid (resp_valid),
    .resp_tid   (resp_tid),
    .resp_data  (resp_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp tid=%h data=%h",
                 resp_tid, resp_data);
      end else begin
        e = sb.pop_front();
        if (resp_tid !== e.tid || resp_data !== e.data ||
            cyc != e.cyc) begin
          errors++;
          $display("FAIL resp got tid=%h data=%h cyc=%0d want tid=%h data=%h cyc=%0d",
                   resp_tid, resp_data, cyc, e.tid, e.data, e.cyc);
        end
      end
    end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL missing_resp tid=%h want data=%h",
               e.tid, e.data);
    end
  end

  task automatic step(
    input logic        wv,
    input logic [15:0] wa,
    input logic [63:0] wd,
    input logic        rv,
    input logic [15:0] ra,
    input logic        want,
    input logic [63:0] exp
  );
    @(posedge clk);
    #1;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    rd_valid = rv;
    rd_addr  = ra;
    rd_tid   = 9'(tidn);
    if (rv && want)
      sb.push_back('{9'(tidn), exp, cyc + 1});
    if (rv) tidn++;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    step(1'b1, a, d, 1'b0, 16'h0, 1'b0, 64'h0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [63:0] e);
    step(1'b0, 16'h0, 64'h0, 1'b1, a, 1'b1, e);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 1'b0, 64'h0);
  endtask

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    rd_tid   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(resp_valid), 64'h0);
    chk("rst_tid", 64'(resp_tid), 64'h0);
    chk("rst_data", resp_data, 64'h0);
    chk("rst_count", 64'(count), 64'h0);

    rd(A_STAT, 64'h100);

    for (int i = 1; i <= 3; i++) wr(A_DATA, 64'(i));
    rd(A_PEEK, 64'h1);
    rd(A_PEEK, 64'h1);
    rd(A_DATA, 64'h1);
    rd(A_DATA, 64'h2);
    rd(A_DATA, 64'h3);
    rd(A_STAT, 64'h100);

    for (int i = 0; i < 9; i++) wr(A_DATA, 64'hA0 + 64'(i));
    rd(A_STAT, 64'h608);
    for (int i = 0; i < 8; i++) rd(A_DATA, 64'hA0 + 64'(i));
    rd(A_DATA, 64'h0);
    rd(A_STAT, 64'hD00);
    wr(A_CTRL, 64'h2);
    rd(A_STAT, 64'h100);

    step(1'b1, A_DATA, 64'hDEAD, 1'b1, A_DATA, 1'b1, 64'h0);
    rd(A_STAT, 64'h801);
    rd(A_DATA, 64'hDEAD);
    rd(A_STAT, 64'h900);

    step(1'b1, A_CTRL, 64'h2, 1'b1, A_DATA, 1'b1, 64'h0);
    rd(A_STAT, 64'h900);
    wr(A_CTRL, 64'h2);

    for (int i = 0; i < 8; i++) wr(A_DATA, 64'hB0 + 64'(i));
    rd(A_STAT, 64'h208);
    step(1'b1, A_DATA, 64'hBEEF, 1'b1, A_DATA, 1'b1, 64'hB0);
    rd(A_STAT, 64'h208);
    for (int i = 1; i < 8; i++) rd(A_DATA, 64'hB0 + 64'(i));
    rd(A_DATA, 64'hBEEF);
    rd(A_DATA, 64'h0);
    rd(A_STAT, 64'h900);

    wr(A_DATA, 64'hE0);
    wr(A_DATA, 64'hE1);
    step(1'b1, A_CTRL, 64'h1, 1'b1, A_DATA, 1'b1, 64'hE0);
    rd(A_STAT, 64'h900);

    for (int i = 0; i < 4; i++) wr(A_DATA, 64'hC0 + 64'(i));
    wr(A_PEEK, 64'h5);
    wr(A_STAT, 64'h5);
    idle();
    @(negedge clk);
    chk("count4", 64'(count), 64'h4);
    rd(A_PEEK, 64'hC0);
    wr(A_CTRL, 64'h3);
    rd(A_STAT, 64'h100);
    rd(A_CTRL, 64'h0);
    rd(A_STAT, 64'h100);
    step(1'b0, 16'h0, 64'h0, 1'b1, 16'h0030, 1'b0, 64'h0);
    idle();
    @(negedge clk);
    chk("miss_valid", 64'(resp_valid), 64'h0);
    chk("miss_hold", resp_data, 64'h100);
    step(1'b0, 16'h0, 64'h0, 1'b1, 16'h0021, 1'b0, 64'h0);
    idle();

    wr(A_DATA, 64'h11);
    wr(A_DATA, 64'h22);
    wr(A_DATA, 64'h33);
    #3 rst = 1'b1;
    #10;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_valid", 64'(resp_valid), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd(A_STAT, 64'h100);
    idle();

    repeat (4) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_queue.md
Name: mmio_queue

Overview:
- MMIO-mapped FIFO queue sitting between the AFU's CCI-P MMIO decode and the tx.c2 read-response path.
- Host pushes 64-bit words by MMIO write and pops or peeks them by MMIO read.
- Block generates the registered read response (valid/tid/data) for its own address window only.
- The AFU top-level muxes this response with DFH/ID responses.

Parameters:
- DEPTH, 8, number of 64-bit entries; 2..255.
- BASE_ADDR, 16'h0020, CCI-P MMIO address of PUSH/POP register (32-bit word units; all registers at even addresses).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  MMIO write strobe (rx.c0.mmioWrValid).
- wr_addr  in  16  MMIO write address.
- wr_data  in  64  MMIO write data (rx.c0.data[63:0]).
- rd_valid  in  1  MMIO read strobe (rx.c0.mmioRdValid).
- rd_addr  in  16  MMIO read address.
- rd_tid  in  9  MMIO read transaction ID.
- resp_valid  out  1  read response valid, one-cycle pulse.
- resp_tid  out  9  tid echoed for response.
- resp_data  out  64  read response data.
- count  out  8  current occupancy (zero-extended).

Behaviour:
- Address map, offsets from BASE_ADDR:
  - +0: write pushes wr_data; read pops head.
  - +2: read = PEEK of head, no pop.
  - +4: read = STATUS. [7:0] count, [8] empty, [9] full, [10] overflow sticky, [11] underflow sticky, others 0.
  - +6: write = CTRL. bit0 flush queue, bit1 clear sticky flags. Reads of +6 return 0.
  - Writes to +2/+4 are ignored.
- Reset: pointers 0, count 0, sticky flags 0, resp_valid 0, resp_tid 0, resp_data 0. Storage contents are don't-care.
- Read latency: exactly 1 cycle. A hit on rd_valid in cycle N gives resp_valid=1 with resp_tid=rd_tid in cycle N+1.
  - resp_valid is 0 in every cycle not following a hit.
  - rd_valid to an address outside {+0,+2,+4,+6} gives no response; resp_data holds its previous value.
- Push when not full: store at tail; tail wraps modulo DEPTH; count+1.
- Push when full (and no pop same cycle): word dropped, overflow sticky set, no other state changes.
- Pop when not empty: resp_data = head entry; head wraps modulo DEPTH; count-1.
- Pop when empty (and no push same cycle): resp_data = 0, underflow sticky set, response still issued.
- PEEK when empty returns 0 and does not set underflow.
- Simultaneous push+pop, same cycle:
  - Not empty: pop returns the pre-push head; count unchanged.
  - Full: both accepted, no overflow.
  - Empty: pop underflows (returns 0, sets flag); the push is stored; count becomes 1.
- STATUS read in the same cycle as a push reflects pre-push state.
- CTRL flush: head = tail = 0, count = 0 next cycle.
  - A pop in the same cycle returns the pre-flush head.
  - If bit0 and bit1 are both set, both actions occur.
- Sticky flags clear only on CTRL bit1 or reset; a set event in the same cycle as the clear wins (flag stays 1).
- Asynchronous reset mid-operation discards all entries and any pending response.

Decomposition:
- Package mmio_queue_pkg:
  - Register offsets OFS_DATA=0, OFS_PEEK=2, OFS_STATUS=4, OFS_CTRL=6.
  - STATUS bit positions.
  - CTRL bit positions.
  - typedef t_mmio_tid (logic [8:0]).
- Sub-module mmio_queue_store holds storage array, head/tail pointers, count, and full/empty.
  - Inputs: push, pop, flush, wdata.
  - Output: head data.
  - mmio_queue wraps it with address decode, sticky flags and the response register.

Test Plan:
- Reset, then read +4 with tid 9'h011: resp_valid one cycle later, tid 9'h011, data 64'h100 (empty=1, count 0).
- Push 1..3 to 16'h0020; read 16'h0022 twice, then 16'h0020 three times -> peeks return 1,1; pops return 1,2,3. Final STATUS = 64'h100.
- Push 9 words (DEPTH=8) A0..A8 -> 9th dropped; STATUS = 64'h608 (count 8, full, overflow). Pops return A0..A7. Extra pop returns 0, sets underflow.
- Empty queue, same-cycle push 64'hDEAD and pop -> pop returns 0, underflow set; count 1; next pop returns 64'hDEAD.
- Full queue, same-cycle push 64'hBEEF and pop -> returns oldest entry, count stays 8, no overflow. Wrap checked by draining 8 pops, BEEF last.
- Push 4 words, write CTRL=64'h3 -> STATUS = 64'h100. Read of 16'h0030 gives no resp_valid. Assert rst mid-push: next STATUS read = 64'h100.
